// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: FSM state encoding and default bus widths.
package apb_pkg;
   localparam int APB_ADDR_W = 8;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_t;
endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; flags expiry on the TIMEOUT-th consecutive
// wait cycle so the master can abort a stuck slave. TIMEOUT=0 never expires.
module apb_wait_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Saturating so a very long stall with TIMEOUT=0 cannot wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && cnt != '1)
         cnt <= cnt + 1'b1;
   end

   assign expired = (TIMEOUT != 0) && (cnt == LAST);
endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one command per handshake, SETUP/ACCESS with PREADY wait states and
// timeout abort, result returned on a one-entry valid/ready response port.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);
   apb_state_t state, state_nxt;
   logic       tmr_clear, tmr_enable, expired, access_done;

   assign tmr_clear   = (state == SETUP);
   assign tmr_enable  = (state == ACCESS) && !PREADY;
   assign access_done = PREADY || expired;
   assign cmd_ready   = (state == IDLE);

   apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk    (PCLK),
      .rst    (PRESET),
      .clear  (tmr_clear),
      .enable (tmr_enable),
      .expired(expired)
   );

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (access_done) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address/direction/data are left in place after the transfer; only PSEL/PENABLE drop.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               PSEL   <= 1'b1;
               PWRITE <= cmd_write;
               PADDR  <= cmd_addr;
               PWDATA <= cmd_wdata;
            end
            SETUP: PENABLE <= 1'b1;
            ACCESS: if (access_done) begin
               PSEL      <= 1'b0;
               PENABLE   <= 1'b0;
               rsp_valid <= 1'b1;
               if (PREADY) begin
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_err   <= PSLVERR;
               end else begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
               end
            end
            RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_cmd_master.sv
// Transaction-level bench: directed cases plus random commands, each predicted from the
// APB transfer rules (latency, wait states, timeout, response hold) by cycle arithmetic.
module tb_apb_cmd_master;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;

   int n_cmp = 0;
   int n_err = 0;

   apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Drives one command and plays the slave; expectations come from the transfer rules:
   // accept at c0, SETUP c1, ACCESS c2..c(1+k), response at c(2+k).
   task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int waits, input logic err, input logic [DW-1:0] rd,
                          input int dly);
      logic          to;
      int            k;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      to      = (TO != 0) && (waits >= TO);
      k       = to ? TO : waits + 1;
      exp_rd  = (to || wr) ? '0 : rd;
      exp_err = to ? 1'b1 : err;

      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); rsp_ready = 1'($urandom);
      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      tick();
      // keep cmd_valid up with junk: must be ignored until back in IDLE
      cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
      chk("setup_psel", 64'(PSEL), 64'(1));
      chk("setup_penable", 64'(PENABLE), 64'(0));
      chk("setup_paddr", 64'(PADDR), 64'(a));
      chk("setup_pwrite", 64'(PWRITE), 64'(wr));
      chk("setup_pwdata", 64'(PWDATA), 64'(wd));
      chk("setup_cmd_ready", 64'(cmd_ready), 64'(0));
      tick();
      for (int i = 0; i < k; i++) begin
         chk("acc_psel", 64'(PSEL), 64'(1));
         chk("acc_penable", 64'(PENABLE), 64'(1));
         chk("acc_paddr", 64'(PADDR), 64'(a));
         chk("acc_pwdata", 64'(PWDATA), 64'(wd));
         chk("acc_rsp_valid", 64'(rsp_valid), 64'(0));
         PREADY  = (i == waits);
         PSLVERR = (i == waits) ? err : 1'($urandom);
         PRDATA  = (i == waits) ? rd : DW'($urandom);
         tick();
      end
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = DW'($urandom);
      for (int j = 0; j <= dly; j++) begin
         chk("rsp_valid", 64'(rsp_valid), 64'(1));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
         chk("rsp_err", 64'(rsp_err), 64'(exp_err));
         chk("rsp_psel", 64'(PSEL), 64'(0));
         chk("rsp_penable", 64'(PENABLE), 64'(0));
         chk("rsp_cmd_ready", 64'(cmd_ready), 64'(0));
         rsp_ready = (j == dly);
         tick();
      end
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("post_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("post_psel", 64'(PSEL), 64'(0));
   endtask

   initial begin
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      #1;
      chk("rst_psel", 64'(PSEL), 64'(0));
      chk("rst_penable", 64'(PENABLE), 64'(0));
      chk("rst_pwrite", 64'(PWRITE), 64'(0));
      chk("rst_paddr", 64'(PADDR), 64'(0));
      chk("rst_pwdata", 64'(PWDATA), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      chk("rst_rsp_err", 64'(rsp_err), 64'(0));
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      tick(); tick();
      PRESET = 1'b0;

      // directed cases
      run_cmd(1'b1, 8'h00, 32'h0000_00FF, 0, 1'b0, 32'hDEAD_BEEF, 0);
      run_cmd(1'b0, 8'h04, 32'h0, 2, 1'b0, 32'h1234_5678, 0);
      run_cmd(1'b0, 8'h10, 32'h0, 0, 1'b1, 32'hCAFE_F00D, 0);
      run_cmd(1'b0, 8'h20, 32'h0, TO, 1'b0, 32'h5555_AAAA, 0);
      run_cmd(1'b0, 8'h24, 32'h0, TO - 1, 1'b0, 32'hA5A5_0F0F, 0);
      run_cmd(1'b1, 8'h30, 32'h0BAD_C0DE, 1, 1'b0, 32'h0, 3);
      run_cmd(1'b1, 8'h34, 32'h1111_2222, 0, 1'b1, 32'h0, 0);

      // reset pulsed mid-ACCESS
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; PREADY = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("pre_rst_penable", 64'(PENABLE), 64'(1));
      tick();
      PRESET = 1'b1;
      #1;
      chk("mid_rst_psel", 64'(PSEL), 64'(0));
      chk("mid_rst_penable", 64'(PENABLE), 64'(0));
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("mid_rst_paddr", 64'(PADDR), 64'(0));
      tick();
      PRESET = 1'b0;
      #1;
      chk("after_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      run_cmd(1'b1, 8'h44, 32'h7777_8888, 0, 1'b0, 32'h0, 0);

      // random traffic
      for (int n = 0; n < 40; n++) begin
         run_cmd(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 6)),
                 1'($urandom), DW'($urandom), int'($urandom_range(0, 3)));
      end

      cmd_valid = 1'b0;
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
